// File: rtl/alu_flag_branch_unit.sv
// Registers ALU result flags (Z/N/C/V) and answers branch-condition queries
// over a valid/ready request with a held done/ack response (2-cycle latency).
module alu_flag_branch_unit #(
    parameter int WIDTH  = 32,
    parameter int COND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    input  logic [WIDTH-1:0]  res_data,
    input  logic              res_carry,
    input  logic              res_ovf,
    output logic [WIDTH-1:0]  result_q,
    output logic              zero,
    output logic              neg,
    output logic              carry,
    output logic              ovf,
    output logic              flags_vld,
    input  logic              br_valid,
    input  logic [COND_W-1:0] br_cond,
    output logic              br_ready,
    output logic              br_done,
    output logic              br_taken,
    output logic              br_err,
    input  logic              br_ack
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

    localparam logic [COND_W-1:0] C_EQ  = COND_W'(0);
    localparam logic [COND_W-1:0] C_NE  = COND_W'(1);
    localparam logic [COND_W-1:0] C_LT  = COND_W'(2);
    localparam logic [COND_W-1:0] C_GE  = COND_W'(3);
    localparam logic [COND_W-1:0] C_LTU = COND_W'(4);
    localparam logic [COND_W-1:0] C_GEU = COND_W'(5);
    localparam logic [COND_W-1:0] C_AL  = COND_W'(6);

    state_t            state, state_nxt;
    logic [COND_W-1:0] snap_cond;
    logic              snap_z, snap_n, snap_c, snap_v, snap_vld;
    logic              accept;
    logic              eval_taken;

    // Flag updates win over queries so a snapshot never races a capture.
    assign br_ready = (state == S_IDLE) && !res_valid;
    assign accept   = br_valid && br_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            flags_vld <= 1'b0;
        end else if (res_valid) begin
            result_q  <= res_data;
            zero      <= ~|res_data;
            neg       <= res_data[WIDTH-1];
            carry     <= res_carry;
            ovf       <= res_ovf;
            flags_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_RESP;
            S_RESP:  if (br_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_cond <= '0;
            snap_z    <= 1'b0;
            snap_n    <= 1'b0;
            snap_c    <= 1'b0;
            snap_v    <= 1'b0;
            snap_vld  <= 1'b0;
        end else if (accept) begin
            snap_cond <= br_cond;
            snap_z    <= zero;
            snap_n    <= neg;
            snap_c    <= carry;
            snap_v    <= ovf;
            snap_vld  <= flags_vld;
        end
    end

    always_comb begin
        eval_taken = 1'b0;
        case (snap_cond)
            C_EQ:    eval_taken = snap_z;
            C_NE:    eval_taken = ~snap_z;
            C_LT:    eval_taken = snap_n ^ snap_v;
            C_GE:    eval_taken = ~(snap_n ^ snap_v);
            C_LTU:   eval_taken = snap_c;
            C_GEU:   eval_taken = ~snap_c;
            C_AL:    eval_taken = 1'b1;
            default: eval_taken = 1'b0;
        endcase
    end

    // Response is latched on the EVAL->RESP edge and held until acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            br_err   <= 1'b0;
        end else if (state == S_EVAL) begin
            br_done  <= 1'b1;
            br_taken <= snap_vld & eval_taken;
            br_err   <= ~snap_vld;
        end else if (state == S_RESP && br_ack) begin
            br_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Bench for alu_flag_branch_unit: reference flag model feeds a response scoreboard;
// directed flag/query scenarios also check outputs against fixed constants.
module tb_alu_flag_branch_unit;

    localparam int WIDTH  = 32;
    localparam int COND_W = 3;

    localparam logic [2:0] EQ = 3'd0, NE = 3'd1, LT = 3'd2, GE = 3'd3;
    localparam logic [2:0] LTU = 3'd4, GEU = 3'd5, AL = 3'd6, NV = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              res_valid;
    logic [WIDTH-1:0]  res_data;
    logic              res_carry, res_ovf;
    logic [WIDTH-1:0]  result_q;
    logic              zero, neg, carry, ovf, flags_vld;
    logic              br_valid;
    logic [COND_W-1:0] br_cond;
    logic              br_ready, br_done, br_taken, br_err, br_ack;

    int n_checks = 0;
    int n_errors = 0;

    alu_flag_branch_unit #(.WIDTH(WIDTH), .COND_W(COND_W)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry), .res_ovf(res_ovf),
        .result_q(result_q), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf),
        .flags_vld(flags_vld),
        .br_valid(br_valid), .br_cond(br_cond), .br_ready(br_ready),
        .br_done(br_done), .br_taken(br_taken), .br_err(br_err), .br_ack(br_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: flags as the block should hold them, plus expected {taken, err}.
    logic m_z, m_n, m_c, m_v, m_vld;
    logic [1:0] sb[$];
    logic [1:0] cur;
    logic acc_flag;
    logic in_resp;
    int   cyc, acc_cyc;

    function automatic logic [1:0] exp_br(input logic [2:0] c, input logic z, input logic n,
                                          input logic cy, input logic v, input logic vld);
        logic t;
        case (c)
            EQ:  t = z;
            NE:  t = !z;
            LT:  t = n != v;
            GE:  t = n == v;
            LTU: t = cy;
            GEU: t = !cy;
            AL:  t = 1'b1;
            default: t = 1'b0;
        endcase
        if (!vld) return 2'b01;
        return {t, 1'b0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_z, m_n, m_c, m_v, m_vld} = '0;
            acc_flag = 1'b0;
            in_resp  = 1'b0;
        end else begin
            acc_flag = br_valid && br_ready;
            if (acc_flag) begin
                sb.push_back(exp_br(br_cond, m_z, m_n, m_c, m_v, m_vld));
                acc_cyc = cyc;
            end
            if (res_valid) begin
                m_z = (res_data == 32'h0);
                m_n = res_data[31];
                m_c = res_carry;
                m_v = res_ovf;
                m_vld = 1'b1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (br_done && !in_resp) begin
                in_resp = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 1, 0);
                    cur = 2'b00;
                end else begin
                    cur = sb.pop_front();
                end
                chk("latency", 32'(cyc - acc_cyc), 2);
                chk("sb_taken", br_taken, cur[1]);
                chk("sb_err", br_err, cur[0]);
            end else if (br_done) begin
                chk("hold_taken", br_taken, cur[1]);
                chk("hold_err", br_err, cur[0]);
            end
            if (!br_done) in_resp = 1'b0;
        end
    end

    task automatic capture(input logic [31:0] d, input logic c, input logic v);
        @(negedge clk);
        res_valid = 1'b1; res_data = d; res_carry = c; res_ovf = v;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic query_start(input logic [2:0] c);
        bit ok = 0;
        br_valid = 1'b1;
        br_cond  = c;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (acc_flag) begin
                ok = 1;
                break;
            end
        end
        br_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (br_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic ack_resp(input int hold);
        repeat (hold) @(negedge clk);
        br_ack = 1'b1;
        @(negedge clk);
        br_ack = 1'b0;
        chk("done_cleared", br_done, 0);
    endtask

    task automatic query(input string tag, input logic [2:0] c, input logic et, input logic ee);
        query_start(c);
        wait_done();
        chk({tag, "_taken"}, br_taken, et);
        chk({tag, "_err"}, br_err, ee);
        ack_resp(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; acc_cyc = 0;
        rst = 1'b1;
        res_valid = 0; res_data = '0; res_carry = 0; res_ovf = 0;
        br_valid = 0; br_cond = '0; br_ack = 0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {result_q != 0, zero, neg, carry, ovf, flags_vld}, 0);
        chk("rst_resp", {br_done, br_taken, br_err}, 0);
        rst = 1'b0;

        // Query before any result: error response, flags still zero.
        query("noflag_eq", EQ, 0, 1);
        chk("noflag_state", {zero, neg, carry, ovf, flags_vld}, 0);

        // Zero flag must be a full reduction.
        capture(32'h0000_0000, 0, 0);
        chk("z_zero", zero, 1);
        chk("z_vld", flags_vld, 1);
        query("eq_zero", EQ, 1, 0);
        capture(32'h0001_0000, 0, 0);
        chk("nz_zero", zero, 0);
        chk("nz_result", result_q, 32'h0001_0000);
        query("ne_nz", NE, 1, 0);
        query("eq_nz", EQ, 0, 0);

        // Signed and unsigned comparisons.
        capture(32'h8000_0000, 0, 0);
        chk("neg_flag", neg, 1);
        query("lt_nv0", LT, 1, 0);
        query("ge_nv0", GE, 0, 0);
        capture(32'h8000_0000, 0, 1);
        chk("ovf_flag", ovf, 1);
        query("lt_nv1", LT, 0, 0);
        capture(32'h0000_0001, 1, 0);
        chk("carry_flag", carry, 1);
        query("ltu_c1", LTU, 1, 0);
        query("geu_c1", GEU, 0, 0);
        query("always", AL, 1, 0);
        query("never", NV, 0, 0);

        // Update and query in the same cycle: update wins, query sees new flags.
        @(negedge clk);
        res_valid = 1; res_data = 32'h0; res_carry = 0; res_ovf = 0;
        br_valid = 1; br_cond = EQ;
        #1;
        chk("ready_blocked", br_ready, 0);
        @(negedge clk);
        res_valid = 0;
        #1;
        chk("ready_after_upd", br_ready, 1);
        query_start(EQ);
        chk("ready_in_eval", br_ready, 0);
        wait_done();
        chk("collide_taken", br_taken, 1);
        ack_resp(0);

        // Snapshot honoured when flags change during evaluation; response held.
        query_start(EQ);
        capture(32'h0000_0005, 0, 0);
        chk("snap_zero_after", zero, 0);
        if (!br_done) wait_done();
        chk("snap_taken", br_taken, 1);
        ack_resp(4);
        query("post_snap_eq", EQ, 0, 0);

        // Async reset while a response is held discards it.
        capture(32'h0, 0, 0);
        query_start(AL);
        wait_done();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_done", br_done, 0);
        chk("rst_async_vld", flags_vld, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        query("post_rst_al", AL, 0, 1);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
